neuron_mac_lanes: RTL and testbench
===================================

NEURON_MAC_LANES -- requirements
Module: neuron_mac_lanes

Interface
REQ-001 Parameter NUM_INPUTS, default 8: dot-product length.
REQ-002 Parameter LANES, default 2: multipliers per cycle; NUM_INPUTS SHALL be a multiple of LANES; NG = NUM_INPUTS/LANES groups.
REQ-003 Parameters X_W 8, W_W 8, B_W 32, OUT_W 16: signed widths of x, w, bias and output.
REQ-004 Parameters X_FRAC 4, W_FRAC 4, B_FRAC 8, OUT_FRAC 8, GUARD_BITS 2: fractional bits and accumulator headroom.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  operation request; in_ready  output  1  high only in IDLE.
REQ-008 bias  input  B_W  signed bias, B_FRAC fractional bits.
REQ-009 x_flat  input  NUM_INPUTS*X_W  and  w_flat  input  NUM_INPUTS*W_W  signed elements, element i at [i*X_W +: X_W] and [i*W_W +: W_W].
REQ-010 mask_flat  input  NUM_INPUTS  1 = use x[i]*w[i], 0 = contribute 0.
REQ-011 act_sel  input  2  00 identity, 01 ReLU, 10 leaky ReLU, 11 clamp to [-1.0, +1.0].
REQ-012 out_valid  output  1  result valid, held until accepted; out_ready  input  1  consumer accept.
REQ-013 out_data  output  OUT_W  signed result, OUT_FRAC fractional bits; out_sat  output  1  result was saturated.
REQ-014 busy  output  1  high in ACC and HOLD.

Function
REQ-015 States SHALL be IDLE, ACC, HOLD.
REQ-016 IDLE: in_valid high -> latch x, w, mask, act_sel; acc = aligned bias; grp = 0; go to ACC.
REQ-017 ACC: each cycle acc += sum of LANES masked products of group grp (elements grp*LANES .. grp*LANES+LANES-1).
REQ-018 ACC, last group: register out_data and out_sat from the updated sum, assert out_valid, go to HOLD.
REQ-019 Latency (macro undefined): out_valid SHALL rise on the NG-th rising edge after the accept edge, independent of mask.
REQ-020 HOLD: out_valid, out_data and out_sat SHALL stay stable while out_ready is low; out_valid and out_ready both high -> IDLE next edge, out_valid low.
REQ-021 in_ready SHALL be low in ACC and HOLD; in_valid there SHALL be ignored; no back-to-back accept in the HOLD-exit cycle.
REQ-022 Product width PROD_W = X_W+W_W; ACC_W = PROD_W + clog2(NUM_INPUTS) (1 if NUM_INPUTS <= 1) + GUARD_BITS; products and bias sign-extended to ACC_W.
REQ-023 Bias alignment: truncate or sign-extend to ACC_W, then shift from B_FRAC to FRAC_P = X_FRAC+W_FRAC; right shifts round half away from zero.
REQ-024 Activation SHALL act on the ACC_W sum: ReLU negative -> 0; leaky negative -> arithmetic shift right 2; clamp to +/-(1 << FRAC_P).
REQ-025 Quantize FRAC_P -> OUT_FRAC with round half away from zero on right shift, left shift otherwise, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat = 1 if clipped.
REQ-026 act_sel values are fully decoded; no value is reserved.

Reset
REQ-027 rst_n low SHALL force IDLE at once: busy 0, out_valid 0, out_data 0, out_sat 0, acc 0, grp 0, latched registers 0.
REQ-028 Reset during ACC or HOLD SHALL discard the operation; no out_valid after reset release without a new accept.

Configuration
REQ-029 Macro NEURON_MAC_LANES_SKIP_EN defined: ACC SHALL process only groups with at least one mask bit set, jumping grp directly to the next such group.
REQ-030 Under this macro latency = max(1, number of non-zero mask groups) cycles; an all-zero mask yields bias-only result after 1 ACC cycle.
REQ-031 Macro undefined: every group is processed; latency fixed at NG cycles (REQ-019).

Verification
REQ-032 Defaults; x[i]=16, w[i]=16, mask 0xFF, bias 0, act 00 -> out_valid 4 cycles after accept, out_data 2048, out_sat 0.
REQ-033 x[i]=16, w[i]=-16, mask 0xFF, bias 0 -> act 00: -2048; 01: 0; 10: -512; 11: -256.
REQ-034 x[i]=127, w[i]=127, mask 0xFF, act 00 -> out_data 32767, out_sat 1; x[i]=127, w[i]=-128 -> out_data -32768, out_sat 1.
REQ-035 out_ready low 5 cycles after out_valid -> out_data stable, in_ready 0, busy 1; out_ready high -> IDLE next edge, in_ready 1.
REQ-036 mask 0x03, x[i]=w[i]=16 -> out_data 512; latency 1 with NEURON_MAC_LANES_SKIP_EN, 4 without.
REQ-037 rst_n low 2 cycles after accept -> out_valid stays 0; next operation returns correct result.

Source files
------------

// File: rtl/neuron_mac_lanes.sv
// Neuron datapath: LANES signed multiply-accumulates per cycle, then bias, activation and quantize.
// Define NEURON_MAC_LANES_SKIP_EN to skip groups whose mask bits are all zero.
module neuron_mac_lanes #(
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned LANES      = 2,
  parameter int unsigned X_W        = 8,
  parameter int unsigned W_W        = 8,
  parameter int unsigned B_W        = 32,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned X_FRAC     = 4,
  parameter int unsigned W_FRAC     = 4,
  parameter int unsigned B_FRAC     = 8,
  parameter int unsigned OUT_FRAC   = 8,
  parameter int unsigned GUARD_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [B_W-1:0]     bias,
  input  logic [NUM_INPUTS*X_W-1:0] x_flat,
  input  logic [NUM_INPUTS*W_W-1:0] w_flat,
  input  logic [NUM_INPUTS-1:0]     mask_flat,
  input  logic [1:0]                act_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_sat,
  output logic                      busy
);
  localparam int unsigned NG     = NUM_INPUTS / LANES;
  localparam int unsigned GW     = (NG > 1) ? $clog2(NG) : 1;
  localparam int unsigned PROD_W = X_W + W_W;
  localparam int unsigned ACC_W  = PROD_W + ((NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1) + GUARD_BITS;
  localparam int unsigned FRAC_P = X_FRAC + W_FRAC;
  localparam int unsigned QSH_R  = (FRAC_P > OUT_FRAC) ? FRAC_P - OUT_FRAC : 0;
  localparam int unsigned QSH_L  = (OUT_FRAC > FRAC_P) ? OUT_FRAC - FRAC_P : 0;
  localparam int unsigned BSH_R  = (B_FRAC > FRAC_P) ? B_FRAC - FRAC_P : 0;
  localparam int unsigned BSH_L  = (FRAC_P > B_FRAC) ? FRAC_P - B_FRAC : 0;
  localparam int unsigned QW     = ((ACC_W + QSH_L > OUT_W) ? ACC_W + QSH_L : OUT_W) + 2;
  localparam int unsigned GXW    = LANES * X_W;
  localparam int unsigned GWW    = LANES * W_W;

  localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(1) <<< FRAC_P;
  localparam logic signed [ACC_W-1:0] NEG_ONE = -ONE;
  localparam logic signed [QW-1:0]    OUT_MAX = {{(QW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [QW-1:0]    OUT_MIN = {{(QW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e                    state_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [GW-1:0]             grp_q;
  logic [NUM_INPUTS*X_W-1:0] x_q;
  logic [NUM_INPUTS*W_W-1:0] w_q;
  logic [NUM_INPUTS-1:0]     mask_q;
  logic [1:0]                act_q;
  logic signed [OUT_W-1:0]   out_data_q;
  logic                      out_sat_q;
  logic                      out_valid_q;

  // Right shift rounding half away from zero; sh == 0 passes through.
  function automatic logic signed [QW-1:0] rnd_shr(input logic signed [QW-1:0] v,
                                                   input int unsigned sh);
    logic signed [QW-1:0] mag;
    if (sh == 0) return v;
    mag = v[QW-1] ? -v : v;
    mag = (mag + (QW'(1) <<< (sh - 1))) >>> sh;
    return v[QW-1] ? -mag : mag;
  endfunction

  // {found, index} of the lowest group >= lo with any mask bit set.
  function automatic logic [GW:0] find_nz(input logic [NUM_INPUTS-1:0] m, input int lo);
    logic [GW:0] r;
    r = '0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (g >= lo && |(LANES'(m >> (g * LANES)))) r = {1'b1, GW'(g)};
    end
    return r;
  endfunction

  logic [GXW-1:0]          x_grp;
  logic [GWW-1:0]          w_grp;
  logic [LANES-1:0]        m_grp, m_sh;
  logic signed [X_W-1:0]   xl;
  logic signed [W_W-1:0]   wl;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] grp_sum, acc_sum, act_val, b_acc, bias_al;
  logic signed [QW-1:0]    qv;
  logic signed [OUT_W-1:0] q_data;
  logic                    q_sat;
  logic [GW-1:0]           grp_first, grp_nxt;
  logic                    last_grp;

  always_comb begin
    x_grp   = GXW'(x_q >> (32'(grp_q) * GXW));
    w_grp   = GWW'(w_q >> (32'(grp_q) * GWW));
    m_grp   = LANES'(mask_q >> (32'(grp_q) * LANES));
    grp_sum = '0;
    m_sh    = '0;
    xl      = '0;
    wl      = '0;
    prod    = '0;
    for (int l = 0; l < LANES; l++) begin
      m_sh = m_grp >> l;
      xl   = X_W'(x_grp >> (l * X_W));
      wl   = W_W'(w_grp >> (l * W_W));
      prod = PROD_W'(xl) * PROD_W'(wl);
      if (m_sh[0]) grp_sum = grp_sum + ACC_W'(prod);
    end
    acc_sum = acc_q + grp_sum;
  end

  always_comb begin
    act_val = acc_sum;
    unique case (act_q)
      2'b00: act_val = acc_sum;
      2'b01: if (acc_sum[ACC_W-1]) act_val = '0;
      2'b10: if (acc_sum[ACC_W-1]) act_val = acc_sum >>> 2;
      2'b11: begin
        if (acc_sum > ONE)          act_val = ONE;
        else if (acc_sum < NEG_ONE) act_val = NEG_ONE;
      end
    endcase
  end

  always_comb begin
    qv     = rnd_shr(QW'(act_val), QSH_R) <<< QSH_L;
    q_sat  = 1'b0;
    q_data = OUT_W'(qv);
    if (qv > OUT_MAX) begin
      q_data = OUT_W'(OUT_MAX);
      q_sat  = 1'b1;
    end else if (qv < OUT_MIN) begin
      q_data = OUT_W'(OUT_MIN);
      q_sat  = 1'b1;
    end
    // Bias is narrowed to the accumulator first, then aligned to the product scale.
    b_acc   = ACC_W'(bias);
    bias_al = ACC_W'(rnd_shr(QW'(b_acc), BSH_R) <<< BSH_L);
  end

  always_comb begin
`ifdef NEURON_MAC_LANES_SKIP_EN
    logic [GW:0] first_r, nxt_r;
    first_r   = find_nz(mask_flat, 0);
    nxt_r     = find_nz(mask_q, int'(grp_q) + 1);
    grp_first = first_r[GW-1:0];
    grp_nxt   = nxt_r[GW-1:0];
    last_grp  = !nxt_r[GW];
`else
    grp_first = '0;
    grp_nxt   = grp_q + 1'b1;
    last_grp  = (grp_q == GW'(NG - 1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      grp_q       <= '0;
      x_q         <= '0;
      w_q         <= '0;
      mask_q      <= '0;
      act_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (in_valid) begin
          x_q     <= x_flat;
          w_q     <= w_flat;
          mask_q  <= mask_flat;
          act_q   <= act_sel;
          acc_q   <= bias_al;
          grp_q   <= grp_first;
          state_q <= StAcc;
        end
        StAcc: begin
          acc_q <= acc_sum;
          grp_q <= grp_nxt;
          if (last_grp) begin
            out_data_q  <= q_data;
            out_sat_q   <= q_sat;
            out_valid_q <= 1'b1;
            state_q     <= StHold;
          end
        end
        StHold: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Directed and randomized bench for neuron_mac_lanes against an arithmetic reference model.
module tb_neuron_mac_lanes;
  localparam int N     = 8;
  localparam int NG    = 4;
  localparam int ACC_W = 21;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_sat, busy;
  logic signed [31:0] bias = '0;
  logic [N*8-1:0] x_flat = '0;
  logic [N*8-1:0] w_flat = '0;
  logic [N-1:0]   mask_flat = '0;
  logic [1:0]     act_sel = '0;
  logic signed [15:0] out_data;

  int checks = 0;
  int errors = 0;
  int xv[N];
  int wv[N];

  always #5 clk = ~clk;

  neuron_mac_lanes dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bias     (bias),
    .x_flat   (x_flat),
    .w_flat   (w_flat),
    .mask_flat(mask_flat),
    .act_sel  (act_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap_acc(input longint v);
    return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  // Dot product in plain integers, then activation, saturation and latency rule.
  task automatic model(input logic [N-1:0] m, input logic signed [31:0] b, input logic [1:0] a,
                       output longint d, output logic s, output int lat);
    longint sum;
    int cnt;
    sum = wrap_acc(longint'(b));
    for (int i = 0; i < N; i++) if (m[i]) sum += longint'(xv[i]) * longint'(wv[i]);
    sum = wrap_acc(sum);
    case (a)
      2'd1: if (sum < 0) sum = 0;
      2'd2: if (sum < 0) sum = sum >>> 2;
      2'd3: begin
        if (sum > 256) sum = 256;
        if (sum < -256) sum = -256;
      end
      default: ;
    endcase
    s = 1'b0;
    d = sum;
    if (sum > 32767) begin d = 32767; s = 1'b1; end
    if (sum < -32768) begin d = -32768; s = 1'b1; end
    cnt = 0;
    for (int g = 0; g < NG; g++) if (m[2*g] || m[2*g+1]) cnt++;
`ifdef NEURON_MAC_LANES_SKIP_EN
    lat = (cnt == 0) ? 1 : cnt;
`else
    lat = NG;
`endif
  endtask

  task automatic fill(input int x, input int w);
    for (int i = 0; i < N; i++) begin
      xv[i] = x;
      wv[i] = w;
    end
  endtask

  task automatic drive_accept(input logic [N-1:0] m, input logic signed [31:0] b,
                              input logic [1:0] a);
    for (int i = 0; i < N; i++) begin
      x_flat[i*8 +: 8] = 8'(xv[i]);
      w_flat[i*8 +: 8] = 8'(wv[i]);
    end
    mask_flat = m;
    bias      = b;
    act_sel   = a;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    // Scramble inputs so the result must come from latched copies.
    x_flat    = {$urandom(), $urandom()};
    w_flat    = {$urandom(), $urandom()};
    mask_flat = N'($urandom());
    act_sel   = 2'($urandom());
    bias      = $urandom();
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] m, input logic signed [31:0] b,
                        input logic [1:0] a, input int hold);
    longint ed;
    logic es;
    int el, lat;
    logic signed [15:0] d0;
    model(m, b, a, ed, es, el);
    chk({tag, ".in_ready"}, in_ready, 1);
    drive_accept(m, b, a);
    chk({tag, ".busy"}, busy, 1);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    chk({tag, ".latency"}, lat, el);
    chk({tag, ".data"}, out_data, ed);
    chk({tag, ".sat"}, out_sat, es);
    d0 = out_data;
    in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_data"}, out_data, d0);
      chk({tag, ".hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ".exit_valid"}, out_valid, 0);
    chk({tag, ".exit_in_ready"}, in_ready, 1);
    chk({tag, ".exit_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", out_valid, 0);
    chk("reset.out_data", out_data, 0);
    chk("reset.out_sat", out_sat, 0);
    chk("reset.busy", busy, 0);
    chk("reset.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fill(16, 16);
    run_op("pos", 8'hFF, 0, 2'b00, 0);
    fill(16, -16);
    run_op("neg_id", 8'hFF, 0, 2'b00, 0);
    run_op("neg_relu", 8'hFF, 0, 2'b01, 1);
    run_op("neg_leaky", 8'hFF, 0, 2'b10, 0);
    run_op("neg_clamp", 8'hFF, 0, 2'b11, 0);
    fill(127, 127);
    run_op("sat_hi", 8'hFF, 0, 2'b00, 0);
    fill(127, -128);
    run_op("sat_lo", 8'hFF, 0, 2'b00, 0);
    fill(16, 16);
    run_op("hold5", 8'hFF, 32'sd300, 2'b00, 5);
    run_op("mask03", 8'h03, 0, 2'b00, 0);
    run_op("mask00", 8'h00, 32'sd1000, 2'b00, 0);
    run_op("mask81", 8'h81, 0, 2'b00, 0);

    // Reset two cycles into an operation must discard it.
    fill(16, 16);
    drive_accept(8'hFF, 0, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (NG + 3) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    chk("rst.no_valid", seen, 0);
    run_op("after_rst", 8'hFF, 0, 2'b00, 0);

    for (int t = 0; t < 24; t++) begin
      logic signed [31:0] b;
      for (int i = 0; i < N; i++) begin
        xv[i] = int'($urandom_range(255)) - 128;
        wv[i] = int'($urandom_range(255)) - 128;
      end
      if (t % 6 == 5) b = $urandom();
      else b = int'($urandom_range(1 << 17)) - (1 << 16);
      run_op($sformatf("rand%0d", t), N'($urandom()), b, 2'($urandom()),
             int'($urandom_range(2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
